// File: rtl/data_memory_stage_block.sv
// Data-memory pipeline stage: issues one bus transaction per load/store and
// holds the upstream pipeline until the ack, then loads the MEM/WB register.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no transaction outstanding; MEM/WB updates every cycle
//   BUSY  | bus request held; waiting for i_bus_ack, upstream stalled
module data_memory_stage_block (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_write_data,
  input  logic [31:0] i_pc_p_4,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_reg_write,
  input  logic [2:0]  i_funct3,
  input  logic [4:0]  i_rd,
  input  logic [1:0]  i_mux_final_result_src,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wstrb,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_stall,
  output logic [31:0] o_alu_result,
  output logic [31:0] o_memory_readout,
  output logic [31:0] o_pc_p_4,
  output logic [1:0]  o_mux_final_result_src,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic        o_valid,
  output logic        o_misaligned
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        is_mem, misaligned, issue;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_fmt;
  logic [3:0]  wstrb_fmt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;

  logic        latch_en, clear_bus;
  logic        valid_d, reg_write_d, misaligned_d;
  logic [31:0] alu_d, readout_d, pc_d;
  logic [4:0]  rd_d;
  logic [1:0]  src_d;

  assign is_mem = i_mem_read | i_mem_write;

  always_comb begin
    misaligned = 1'b0;
    case (i_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = i_alu_result[0];
      default: misaligned = |i_alu_result[1:0];
    endcase
  end

  assign issue = (state_q == IDLE) && i_valid && is_mem && !misaligned;
  assign o_stall = !i_reset && ((state_q == BUSY) || issue);
  assign o_bus_req = (state_q == BUSY);

  // Store lanes follow the byte offset; data is replicated so any lane carries it.
  always_comb begin
    case (i_funct3[1:0])
      2'b00: begin
        wstrb_fmt = 4'b0001 << i_alu_result[1:0];
        wdata_fmt = {4{i_write_data[7:0]}};
      end
      2'b01: begin
        wstrb_fmt = 4'b0011 << i_alu_result[1:0];
        wdata_fmt = {2{i_write_data[15:0]}};
      end
      default: begin
        wstrb_fmt = 4'b1111;
        wdata_fmt = i_write_data;
      end
    endcase
  end

  always_comb begin
    case (off_q)
      2'd0:    byte_sel = i_bus_rdata[7:0];
      2'd1:    byte_sel = i_bus_rdata[15:8];
      2'd2:    byte_sel = i_bus_rdata[23:16];
      default: byte_sel = i_bus_rdata[31:24];
    endcase
    half_sel = off_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   load_val = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
      default: load_val = i_bus_rdata;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Default MEM/WB content is a bubble; only completed instructions overwrite it.
  always_comb begin
    state_d      = state_q;
    latch_en     = 1'b0;
    clear_bus    = 1'b0;
    valid_d      = 1'b0;
    reg_write_d  = 1'b0;
    misaligned_d = 1'b0;
    alu_d        = 32'd0;
    readout_d    = 32'd0;
    pc_d         = 32'd0;
    rd_d         = 5'd0;
    src_d        = 2'd0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d  = BUSY;
          latch_en = 1'b1;
        end else if (i_valid) begin
          valid_d      = 1'b1;
          reg_write_d  = is_mem ? 1'b0 : i_reg_write;
          misaligned_d = is_mem;
          alu_d        = i_alu_result;
          pc_d         = i_pc_p_4;
          rd_d         = i_rd;
          src_d        = i_mux_final_result_src;
        end
      end
      BUSY: begin
        if (i_bus_ack) begin
          state_d     = IDLE;
          clear_bus   = 1'b1;
          valid_d     = 1'b1;
          reg_write_d = i_reg_write;
          readout_d   = o_bus_we ? 32'd0 : load_val;
          alu_d       = i_alu_result;
          pc_d        = i_pc_p_4;
          rd_d        = i_rd;
          src_d       = i_mux_final_result_src;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_bus_we               <= 1'b0;
      o_bus_addr             <= 32'd0;
      o_bus_wdata            <= 32'd0;
      o_bus_wstrb            <= 4'd0;
      off_q                  <= 2'd0;
      f3_q                   <= 3'd0;
      o_valid                <= 1'b0;
      o_reg_write            <= 1'b0;
      o_misaligned           <= 1'b0;
      o_alu_result           <= 32'd0;
      o_memory_readout       <= 32'd0;
      o_pc_p_4               <= 32'd0;
      o_rd                   <= 5'd0;
      o_mux_final_result_src <= 2'd0;
    end else begin
      if (latch_en) begin
        o_bus_we    <= i_mem_write;
        o_bus_addr  <= {i_alu_result[31:2], 2'b00};
        o_bus_wdata <= i_mem_write ? wdata_fmt : 32'd0;
        o_bus_wstrb <= i_mem_write ? wstrb_fmt : 4'd0;
        off_q       <= i_alu_result[1:0];
        f3_q        <= i_funct3;
      end else if (clear_bus) begin
        o_bus_we    <= 1'b0;
        o_bus_addr  <= 32'd0;
        o_bus_wdata <= 32'd0;
        o_bus_wstrb <= 4'd0;
      end
      o_valid                <= valid_d;
      o_reg_write            <= reg_write_d;
      o_misaligned           <= misaligned_d;
      o_alu_result           <= alu_d;
      o_memory_readout       <= readout_d;
      o_pc_p_4               <= pc_d;
      o_rd                   <= rd_d;
      o_mux_final_result_src <= src_d;
    end
  end

endmodule

// File: doc/data_memory_stage_block.md
DATA_MEMORY_STAGE_BLOCK -- requirements
Module: data_memory_stage_block

Interface
REQ-001 SHALL have port i_clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port i_reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port i_valid, input, 1: EX/MEM slot holds a real instruction.
REQ-004 SHALL have ports i_alu_result / i_write_data / i_pc_p_4, input, 32 each: address or ALU value, store data, PC+4.
REQ-005 SHALL have ports i_mem_read, i_mem_write, i_reg_write, input, 1 each; i_funct3, input, 3; i_rd, input, 5; i_mux_final_result_src, input, 2.
REQ-006 SHALL have bus ports o_bus_req (1), o_bus_we (1), o_bus_addr (32, bits[1:0]=0), o_bus_wdata (32), o_bus_wstrb (4), all output; i_bus_ack (1), i_bus_rdata (32), both input.
REQ-007 SHALL have o_stall, output, 1: upstream stages hold their registers while high.
REQ-008 SHALL have MEM/WB register outputs: o_alu_result, o_memory_readout, o_pc_p_4 (32 each); o_mux_final_result_src (2); o_rd (5); o_reg_write, o_valid, o_misaligned (1 each).

Function
REQ-009 SHALL implement FSM states IDLE and BUSY.
REQ-010 IDLE, i_valid=1, memory op (i_mem_read|i_mem_write), aligned: SHALL assert o_stall combinationally, latch address, we, wdata and wstrb, and go to BUSY next edge; MEM/WB loads a bubble (o_valid=0, o_reg_write=0).
REQ-011 BUSY: o_bus_req=1 and bus outputs stable until the cycle i_bus_ack=1; o_stall=1 throughout BUSY, including the ack cycle.
REQ-012 On the edge ending the ack cycle: SHALL load MEM/WB with the held instruction (o_valid=1, loads: extracted readout), deassert o_bus_req, return to IDLE; o_stall low next cycle.
REQ-013 Minimum memory-op latency SHALL be 2 cycles (IDLE + 1 BUSY ack cycle) from issue to o_valid.
REQ-014 Non-memory op (i_valid=1, no mem op): SHALL load MEM/WB in one cycle, no stall; i_valid=0 loads a bubble.
REQ-015 i_mem_read and i_mem_write both high: SHALL treat as store; read ignored.
REQ-016 Stores: SB wstrb=0001<<addr[1:0], wdata=byte replicated x4; SH wstrb=0011<<addr[1:0], wdata=half replicated x2; SW wstrb=1111, wdata=i_write_data.
REQ-017 Loads: LB/LBU select byte addr[1:0], sign-/zero-extend; LH/LHU select half addr[1]; LW full word; funct3 011/110/111 SHALL behave as LW.
REQ-018 Misaligned (LH/SH/LHU addr[0]=1; LW/SW addr[1:0]!=0): no bus access, no stall; MEM/WB loads o_valid=1, o_reg_write=0, o_misaligned=1 for one cycle.
REQ-019 i_bus_ack while IDLE SHALL be ignored.
REQ-020 o_memory_readout SHALL be 0 for non-load instructions; other MEM/WB fields pass through from inputs.
REQ-021 Bus request never starts without upstream inputs being held; upstream SHALL not change inputs while o_stall=1.

Reset
REQ-022 i_reset=1 SHALL immediately force FSM to IDLE and every output (bus, o_stall, all MEM/WB fields) to 0, including mid-BUSY; pending transaction abandoned.
REQ-023 After reset release, first edge SHALL process inputs normally.

Verification
REQ-024 LW addr 0x100, ack after 3 BUSY cycles, rdata 0xDEADBEEF -> o_stall high 4 cycles, o_bus_addr 0x100, then o_valid=1, o_memory_readout=0xDEADBEEF.
REQ-025 LB addr 0x103, rdata 0x80FF_FF00 -> readout 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
REQ-026 SB addr 0x201, data 0x123456AB -> o_bus_addr 0x200, wstrb 0010, wdata 0xABABABAB, o_bus_we=1.
REQ-027 LW addr 0x102 -> no o_bus_req, no stall, o_misaligned=1, o_reg_write=0 one cycle.
REQ-028 Reset pulsed during BUSY before ack -> o_bus_req and o_stall 0 immediately, o_valid 0; later ack ignored.
REQ-029 Back-to-back ADD, SW, ADD with 1-cycle ack -> ADD o_valid next cycle, SW stall 2 cycles, second ADD follows SW's o_valid by one cycle.
